// File: rtl/led_breathe.sv
// Multi-channel LED "breathing" PWM generator: a prescaled phase accumulator
// drives per-channel sawtooth/triangle levels, which are latched into shadow
// registers at PWM period boundaries and compared against a free-running counter.
module led_breathe #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned PWM_W   = 8,
    parameter int unsigned PRESC_W = 20
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [PWM_W:0]     phase_step,
    output logic [NCH-1:0]     o,
    output logic [PWM_W-1:0]   level0,
    output logic               wrap
);

    localparam int unsigned PhW = PWM_W + 1;
    localparam logic [PWM_W-1:0] CntMax = '1;
    localparam logic [PWM_W:0]   AccMax = '1;

    typedef enum logic [1:0] {
        ModeOff  = 2'b00,
        ModeSaw  = 2'b01,
        ModeTri  = 2'b10,
        ModeHold = 2'b11
    } mode_e;

    mode_e mode_m;
    logic  off;
    logic  ramp_run;
    logic  tick;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_W:0]     acc_q, acc_d;
    logic [PWM_W-1:0]   cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [NCH-1:0]     o_q, o_d;
    logic [PWM_W:0]     phase_k [NCH];
    logic [PWM_W-1:0]   level_d [NCH];
    logic [PWM_W-1:0]   shadow_q [NCH];
    logic [PWM_W-1:0]   shadow_d [NCH];

    assign mode_m   = mode_e'(mode);
    assign off      = (mode_m == ModeOff);
    assign ramp_run = en && ((mode_m == ModeSaw) || (mode_m == ModeTri));
    // Compare with >= so a presc lowered below the running count fires at once.
    assign tick     = ramp_run && (presc_cnt_q >= presc);

    // Ramp next-state: prescaler, phase accumulator, wrap pulse and PWM counter.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        acc_d       = acc_q;
        wrap_d      = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (off) begin
            presc_cnt_d = '0;
            acc_d       = '0;
            cnt_d       = '0;
        end else if (ramp_run) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
            if (tick) begin
                acc_d  = acc_q + 1'b1;
                wrap_d = (acc_q == AccMax);
            end
        end
    end

    // Per-channel level, shadow reload at the PWM boundary and compare output.
    always_comb begin
        o_d = '0;
        for (int k = 0; k < NCH; k++) begin
            phase_k[k] = acc_q + PhW'(k) * phase_step;
            if (mode_m == ModeSaw) begin
                level_d[k] = phase_k[k][PWM_W-1:0];
            end else begin
                // Triangle: fold the upper half so peak and zero each last two steps.
                level_d[k] = phase_k[k][PWM_W] ? ~phase_k[k][PWM_W-1:0]
                                               : phase_k[k][PWM_W-1:0];
            end
            // Loading from the current accumulator gives the pre-tick level on a
            // coincident tick.
            shadow_d[k] = (!off && (cnt_q == CntMax)) ? level_d[k] : shadow_q[k];
            o_d[k]      = !off && (cnt_q < shadow_q[k]);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_cnt_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            o_q         <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            presc_cnt_q <= presc_cnt_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            o_q         <= o_d;
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign o      = o_q;
    assign wrap   = wrap_q;
    assign level0 = shadow_q[0];

endmodule

// File: tb/tb_led_breathe.sv
// Self-checking bench for led_breathe: a cycle model pushes expected
// {o, wrap, level0} at each rising edge, popped and compared on the falling edge,
// plus directed duty-cycle counts and asynchronous reset checks.
module tb_led_breathe;

    localparam int unsigned NCH     = 4;
    localparam int unsigned PWM_W   = 8;
    localparam int unsigned PRESC_W = 20;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [1:0]         mode;
    logic [PRESC_W-1:0] presc;
    logic [PWM_W:0]     phase_step;
    logic [NCH-1:0]     o;
    logic [PWM_W-1:0]   level0;
    logic               wrap;

    int n_checks = 0;
    int n_errors = 0;
    int duty [NCH];

    led_breathe #(
        .NCH    (NCH),
        .PWM_W  (PWM_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .en        (en),
        .mode      (mode),
        .presc     (presc),
        .phase_step(phase_step),
        .o         (o),
        .level0    (level0),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PRESC_W-1:0] m_p;
    logic [8:0]         m_a;
    logic [7:0]         m_c;
    logic [7:0]         m_s [NCH];
    logic [7:0]         n_s [NCH];
    logic [NCH-1:0]     n_o;
    logic [8:0]         m_ph [NCH];
    logic [7:0]         m_lvl [NCH];
    logic [12:0]        sb [$];

    wire m_off  = (mode == 2'b00);
    wire m_run  = en && (mode == 2'b01 || mode == 2'b10);
    wire m_tick = m_run && (m_p >= presc);

    always_comb begin
        n_o = '0;
        for (int k = 0; k < NCH; k++) begin
            m_ph[k] = m_a + 9'(k) * phase_step;
            if (mode == 2'b01) m_lvl[k] = m_ph[k][7:0];
            else if (m_ph[k] < 9'd256) m_lvl[k] = m_ph[k][7:0];
            else m_lvl[k] = 8'(9'd511 - m_ph[k]);
            n_s[k] = (!m_off && m_c == 8'd255) ? m_lvl[k] : m_s[k];
            n_o[k] = !m_off && (m_c < m_s[k]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p <= '0;
            m_a <= '0;
            m_c <= '0;
            for (int k = 0; k < NCH; k++) m_s[k] <= '0;
            sb.delete();
        end else begin
            m_p <= m_off ? '0 : (m_run ? (m_tick ? '0 : m_p + 1'b1) : m_p);
            m_a <= m_off ? '0 : (m_tick ? m_a + 1'b1 : m_a);
            m_c <= m_off ? '0 : m_c + 1'b1;
            for (int k = 0; k < NCH; k++) m_s[k] <= n_s[k];
            sb.push_back({n_o, (!m_off && m_tick && m_a == 9'd511), n_s[0]});
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [12:0] exp_v;
            exp_v = sb.pop_front();
            check_eq("cycle", {19'd0, o, wrap, level0}, {19'd0, exp_v});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_duty();
        for (int k = 0; k < NCH; k++) duty[k] = 0;
        repeat (256) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) duty[k] += int'(o[k]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        mode       = 2'b11;
        presc      = '0;
        phase_step = 9'd128;
        #12;
        check_eq("rst_o", {28'd0, o}, 32'd0);
        check_eq("rst_wrap", {31'd0, wrap}, 32'd0);
        check_eq("rst_level0", {24'd0, level0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hold at A=0: S0=0 stays low, channel 2 sits at full scale.
        cycles(300);
        measure_duty();
        check_eq("hold0_ch0", duty[0], 0);
        check_eq("hold0_ch1", duty[1], 128);
        check_eq("hold0_ch2", duty[2], 255);
        check_eq("hold0_ch3", duty[3], 127);

        // Sawtooth 64 ticks at presc=0, then hold at A=64.
        @(negedge clk);
        mode = 2'b01;
        cycles(64);
        mode = 2'b11;
        cycles(300);
        measure_duty();
        check_eq("hold64_ch0", duty[0], 64);
        check_eq("hold64_ch1", duty[1], 192);
        check_eq("hold64_ch2", duty[2], 191);
        check_eq("hold64_ch3", duty[3], 63);

        // Triangle with an odd phase offset.
        mode       = 2'b10;
        presc      = 20'd2;
        phase_step = 9'd37;
        cycles(3000);

        // Sawtooth at full rate: wraps every 512 clocks.
        mode       = 2'b01;
        presc      = '0;
        phase_step = '0;
        cycles(1200);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_o", {28'd0, o}, 32'd0);
        check_eq("async_wrap", {31'd0, wrap}, 32'd0);
        check_eq("async_level0", {24'd0, level0}, 32'd0);
        mode  = 2'b10;
        presc = 20'd1000;
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler lowered while running at P=500, then en frozen.
        cycles(500);
        presc = 20'd3;
        cycles(40);
        en = 1'b0;
        cycles(50);
        en = 1'b1;
        cycles(600);

        // Off, then restart the triangle from zero.
        mode = 2'b00;
        cycles(20);
        check_eq("off_o", {28'd0, o}, 32'd0);
        mode  = 2'b10;
        presc = 20'd1;
        cycles(600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
